ysyx_25060170_ifu: RTL and testbench

Multi-cycle instruction fetch unit for the NPC core. It owns the architectural PC, issues read requests to instruction memory over a valid/ready address/data channel, and presents the fetched instruction and its PC to the decode stage. It then holds the instruction until the core commits it and returns the next PC. It is the producer end of the decode stage's `pc_i`/`inst_i` inputs.

---
 rtl/ysyx_25060170_ifu.sv | 133 +++++++++++++
 tb/tb_ysyx_25060170_ifu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifu.sv
// rtl/ysyx_25060170_ifu.sv - multi-cycle instruction fetch unit with held instruction and commit-driven PC
module ysyx_25060170_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_npc_i,
    output logic        fetch_err_o,
    output logic [31:0] err_pc_o,
    output logic [31:0] inst_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_VALID = 3'd3,
        S_EXEC  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;

    logic ar_fire;
    logic r_fire;
    logic r_ok;
    logic r_fault;
    logic dec_fire;
    logic commit_fire;
    logic npc_misaligned;

    // Handshake qualifiers; each is only meaningful in the state that owns it.
    always_comb begin
        ar_fire        = arvalid_o & arready_i;
        r_fire         = rvalid_i & rready_o;
        r_ok           = r_fire & (rresp_i == 2'b00);
        r_fault        = r_fire & (rresp_i != 2'b00);
        dec_fire       = inst_valid_o & inst_ready_i;
        commit_fire    = (state == S_EXEC) & commit_valid_i;
        npc_misaligned = commit_npc_i[1:0] != 2'b00;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; inputs not owned by the current state are ignored.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_AR;
            S_AR:    if (ar_fire) state_next = S_R;
            S_R: begin
                if (r_ok)         state_next = S_VALID;
                else if (r_fault) state_next = S_ERR;
            end
            S_VALID: if (dec_fire) state_next = S_EXEC;
            S_EXEC: begin
                if (commit_fire) state_next = npc_misaligned ? S_ERR : S_AR;
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the state register, so they never glitch on inputs.
    always_comb begin
        arvalid_o    = (state == S_AR);
        rready_o     = (state == S_R);
        inst_valid_o = (state == S_VALID);
        fetch_err_o  = (state == S_ERR);
        araddr_o     = pc;
        pc_o         = pc;
    end

    // PC only moves on an accepted commit, so the address is stable through AR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (commit_fire && !npc_misaligned) begin
            pc <= commit_npc_i;
        end
    end

    // Instruction word captured on a good data beat and held through VALID and EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_o <= 32'h0;
        end else if (state == S_R && r_ok) begin
            inst_o <= rdata_i;
        end
    end

    // Fault address: the fetch PC for a bus fault, the offending npc for a misaligned redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pc_o <= 32'h0;
        end else if (state == S_R && r_fault) begin
            err_pc_o <= pc;
        end else if (commit_fire && npc_misaligned) begin
            err_pc_o <= commit_npc_i;
        end
    end

    // Decode-accepted instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_cnt_o <= 32'h0;
        end else if (dec_fire) begin
            inst_cnt_o <= inst_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// tb/tb_ysyx_25060170_ifu.sv - self-checking bench for ysyx_25060170_ifu
module tb_ysyx_25060170_ifu;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        commit_valid;
    logic [31:0] commit_npc;
    logic        fetch_err;
    logic [31:0] err_pc;
    logic [31:0] inst_cnt;

    int passed = 0;
    int total  = 0;

    ysyx_25060170_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
        .pc_o(pc), .inst_o(inst), .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .commit_valid_i(commit_valid), .commit_npc_i(commit_npc),
        .fetch_err_o(fetch_err), .err_pc_o(err_pc), .inst_cnt_o(inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'b0, arvalid}, 32'h0);
        chk({tag, "_rready"}, {31'b0, rready}, 32'h0);
        chk({tag, "_ivalid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_err"}, {31'b0, fetch_err}, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_errpc"}, err_pc, 32'h0);
        chk({tag, "_cnt"}, inst_cnt, 32'h0);
        chk({tag, "_araddr"}, araddr, 32'h8000_0000);
    endtask

    // Transaction-level reference: which handshake the fetch unit is waiting for next.
    localparam int WANT_ADDR = 0;
    localparam int WANT_DATA = 1;
    localparam int WANT_DEC  = 2;
    localparam int WANT_CMT  = 3;

    int          phase;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_cnt;
    logic [31:0] rnd;
    int          fetched;

    initial begin
        rst = 1'b1; arready = 1'b1; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        inst_ready = 1'b0; commit_valid = 1'b0; commit_npc = 32'h0;
        #1;
        chk_idle_outputs("reset_t0");
        repeat (3) begin
            step();
            chk_idle_outputs("reset_hold");
        end

        // Boot: first edge after release enters AR; stale rvalid there must be ignored.
        rst = 1'b0;
        step();
        chk("boot_arvalid", {31'b0, arvalid}, 32'h1);
        chk("boot_araddr", araddr, 32'h8000_0000);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        step();
        chk("ar_rvalid_ignored_inst", inst, 32'h0);
        chk("r_rready", {31'b0, rready}, 32'h1);
        chk("r_arvalid_low", {31'b0, arvalid}, 32'h0);

        // Zero-wait fetch.
        rdata = 32'h0010_0073; arready = 1'b0;
        step();
        rvalid = 1'b0;
        chk("zw_ivalid", {31'b0, inst_valid}, 32'h1);
        chk("zw_inst", inst, 32'h0010_0073);
        chk("zw_pc", pc, 32'h8000_0000);
        inst_ready = 1'b1;
        step();
        chk("zw_cnt", inst_cnt, 32'h1);
        chk("zw_ivalid_drop", {31'b0, inst_valid}, 32'h0);

        // Redirect with inst_ready also high: only the commit applies in EXEC.
        commit_valid = 1'b1; commit_npc = 32'h8000_0010;
        step();
        commit_valid = 1'b0; inst_ready = 1'b0;
        chk("redir_arvalid", {31'b0, arvalid}, 32'h1);
        chk("redir_araddr", araddr, 32'h8000_0010);
        chk("redir_cnt", inst_cnt, 32'h1);

        // Address backpressure.
        repeat (3) begin
            step();
            chk("bp_arvalid", {31'b0, arvalid}, 32'h1);
            chk("bp_araddr", araddr, 32'h8000_0010);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("bp_in_r", {31'b0, rready}, 32'h1);

        // Commit pulse in R is ignored; data delayed four cycles.
        commit_valid = 1'b1; commit_npc = 32'h1234_5678;
        step();
        commit_valid = 1'b0;
        chk("r_commit_ignored_pc", pc, 32'h8000_0010);
        chk("r_commit_ignored_rready", {31'b0, rready}, 32'h1);
        repeat (3) begin
            step();
            chk("rdelay_rready", {31'b0, rready}, 32'h1);
            chk("rdelay_no_dup", {31'b0, arvalid}, 32'h0);
        end
        rvalid = 1'b1; rdata = 32'hCAFE_0013;
        step();
        rvalid = 1'b0; rdata = 32'h0;
        repeat (2) begin
            step();
            chk("dbp_ivalid", {31'b0, inst_valid}, 32'h1);
            chk("dbp_inst", inst, 32'hCAFE_0013);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("dbp_cnt", inst_cnt, 32'h2);
        chk("exec_inst_held", inst, 32'hCAFE_0013);

        // Bus fault at 0x8000_0004.
        commit_valid = 1'b1; commit_npc = 32'h8000_0004;
        step();
        commit_valid = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'b10;
        step();
        rvalid = 1'b0; rresp = 2'b00;
        chk("rfault_err", {31'b0, fetch_err}, 32'h1);
        chk("rfault_errpc", err_pc, 32'h8000_0004);
        commit_valid = 1'b1; commit_npc = 32'h0; arready = 1'b1;
        repeat (3) begin
            step();
            chk("err_absorb_arvalid", {31'b0, arvalid}, 32'h0);
            chk("err_absorb_err", {31'b0, fetch_err}, 32'h1);
            chk("err_absorb_pc", pc, 32'h8000_0004);
        end
        commit_valid = 1'b0; arready = 1'b0;

        // Misaligned redirect fault.
        rst = 1'b1;
        step();
        chk("rst2_err", {31'b0, fetch_err}, 32'h0);
        chk("rst2_pc", pc, 32'h8000_0000);
        rst = 1'b0;
        step();
        arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
        step();
        rvalid = 1'b0; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0; commit_valid = 1'b1; commit_npc = 32'h8000_0006;
        step();
        commit_valid = 1'b0;
        chk("mis_err", {31'b0, fetch_err}, 32'h1);
        chk("mis_errpc", err_pc, 32'h8000_0006);
        chk("mis_arvalid", {31'b0, arvalid}, 32'h0);

        // Reset mid-R with a late data beat afterwards.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("midr_in_r", {31'b0, rready}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midr_async_rready", {31'b0, rready}, 32'h0);
        chk("midr_async_errpc", err_pc, 32'h0);
        step();
        rst = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        chk("midr_arvalid", {31'b0, arvalid}, 32'h1);
        chk("midr_araddr", araddr, 32'h8000_0000);
        chk("midr_stale_inst", inst, 32'h0);
        chk("midr_cnt", inst_cnt, 32'h0);

        // Randomized traffic against the transaction-level model, starting in address phase.
        phase = WANT_ADDR; exp_pc = 32'h8000_0000; exp_inst = 32'h0; exp_cnt = 32'h0; fetched = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_arvalid", {31'b0, arvalid}, {31'b0, phase == WANT_ADDR});
            chk("rnd_rready", {31'b0, rready}, {31'b0, phase == WANT_DATA});
            chk("rnd_ivalid", {31'b0, inst_valid}, {31'b0, phase == WANT_DEC});
            chk("rnd_err", {31'b0, fetch_err}, 32'h0);
            chk("rnd_araddr", araddr, exp_pc);
            chk("rnd_pc", pc, exp_pc);
            chk("rnd_cnt", inst_cnt, exp_cnt);
            if (phase == WANT_DEC || phase == WANT_CMT) chk("rnd_inst", inst, exp_inst);

            arready      = ($urandom % 3) == 0;
            rvalid       = ($urandom % 3) == 0;
            rdata        = $urandom;
            rresp        = 2'b00;
            inst_ready   = ($urandom % 2) == 0;
            commit_valid = ($urandom % 4) == 0;
            rnd          = $urandom;
            commit_npc   = {rnd[31:2], 2'b00};

            if (phase == WANT_ADDR && arready) begin
                phase = WANT_DATA;
            end else if (phase == WANT_DATA && rvalid) begin
                exp_inst = rdata;
                phase = WANT_DEC;
            end else if (phase == WANT_DEC && inst_ready) begin
                exp_cnt = exp_cnt + 1;
                phase = WANT_CMT;
            end else if (phase == WANT_CMT && commit_valid) begin
                exp_pc = commit_npc;
                fetched++;
                phase = WANT_ADDR;
            end
            step();
        end
        chk("rnd_progress", {31'b0, fetched > 20}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
